// File: rtl/store_buffer_pkg.sv
// Shared processor constants for the store buffer: default geometry and
// the word-alignment mask applied to store addresses.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Stores are whole words; any set bit under this mask marks a misaligned store.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry storage for the store buffer: address/data slots, per-slot
// valid bits, head/tail pointers and occupancy count.
import store_buffer_pkg::*;

module store_buffer_fifo #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [PTR_W-1:0]  head_ptr,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] entry_addr [DEPTH],
  output logic [DATA_W-1:0] entry_data [DEPTH],
  output logic [DEPTH-1:0]  entry_valid
);

  logic [PTR_W-1:0] tail_ptr;

  // Callers never push when full nor pop when empty, so head and tail never
  // address the same slot in one cycle; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      entry_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      if (push) begin
        entry_addr[tail_ptr]  <= push_addr;
        entry_data[tail_ptr]  <= push_data;
        entry_valid[tail_ptr] <= 1'b1;
        tail_ptr              <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: accepts aligned core stores, drains them FIFO to
// data memory and forwards the youngest matching store to core loads.
// Handshake: a store is taken when cpu_we=1 and cpu_stall=0 at the edge;
// the head is retired when mem_req=1 and mem_ack=1 at the edge.
import store_buffer_pkg::*;

module store_buffer #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              align_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  count
);

  logic              push;
  logic              pop;
  logic              aligned;
  logic [PTR_W-1:0]  head_ptr;
  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic [PTR_W-1:0]  scan_idx;

  assign aligned   = is_aligned(cpu_addr[1:0]);
  assign cpu_stall = (count == CNT_W'(DEPTH));
  assign push      = cpu_we && !cpu_stall && aligned;
  assign mem_req   = (count != '0);
  assign pop       = mem_req && mem_ack;

  // Head slot is held until acked; gate to zero so an empty buffer drives 0.
  assign mem_addr  = mem_req ? entry_addr[head_ptr] : '0;
  assign mem_wdata = mem_req ? entry_data[head_ptr] : '0;

  store_buffer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_addr   (cpu_addr),
    .push_data   (cpu_wdata),
    .head_ptr    (head_ptr),
    .count       (count),
    .entry_addr  (entry_addr),
    .entry_data  (entry_data),
    .entry_valid (entry_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) align_err <= 1'b0;
    else     align_err <= cpu_we && !cpu_stall && !aligned;
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PTR_W'(k);
      if (entry_valid[scan_idx] && entry_addr[scan_idx] == cpu_raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based
// model of the buffer contents.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_stall;
  logic [ADDR_W-1:0] cpu_raddr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              align_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_raddr(cpu_raddr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .align_err(align_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count)
  );

  // clock/reset
  always #5 clk = ~clk;

  // model state: buffered stores oldest-first, and drain scoreboard
  logic [ADDR_W-1:0] mdl_addr[$];
  logic [DATA_W-1:0] mdl_data[$];
  logic [ADDR_W-1:0] exp_q[$];
  logic              exp_align;
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic              e_hit;
    logic [DATA_W-1:0] e_fwd;
    e_hit = 1'b0;
    e_fwd = '0;
    for (int i = mdl_addr.size() - 1; i >= 0; i--) begin
      if (!e_hit && mdl_addr[i] == cpu_raddr) begin
        e_hit = 1'b1;
        e_fwd = mdl_data[i];
      end
    end
    check("count",     64'(count),     64'(mdl_addr.size()));
    check("cpu_stall", 64'(cpu_stall), 64'(mdl_addr.size() == DEPTH));
    check("mem_req",   64'(mem_req),   64'(mdl_addr.size() != 0));
    check("mem_addr",  64'(mem_addr),  64'(mdl_addr.size() != 0 ? mdl_addr[0] : '0));
    check("mem_wdata", 64'(mem_wdata), 64'(mdl_data.size() != 0 ? mdl_data[0] : '0));
    check("fwd_hit",   64'(fwd_hit),   64'(e_hit));
    check("fwd_data",  64'(fwd_data),  64'(e_fwd));
    check("align_err", 64'(align_err), 64'(exp_align));
  endtask

  // driver: present one cycle of inputs, check, then advance model and clock
  task automatic step(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] raddr,
                      input logic ack);
    logic full, acc, popd;
    cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_raddr = raddr; mem_ack = ack;
    #1;
    check_outputs();
    full = (mdl_addr.size() == DEPTH);
    acc  = we && !full && (addr % 4 == 0);
    popd = ack && (mdl_addr.size() != 0);
    if (popd) begin
      if (exp_q.size() == 0) check("drain_unexpected", 64'(mem_addr), 64'hx);
      else check("drain_order", 64'(mem_addr), 64'(exp_q.pop_front()));
      void'(mdl_addr.pop_front());
      void'(mdl_data.pop_front());
    end
    exp_align = we && !full && (addr % 4 != 0);
    if (acc) begin
      mdl_addr.push_back(addr);
      mdl_data.push_back(data);
      exp_q.push_back(addr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    step(1'b0, '0, '0, '0, ack);
  endtask

  initial begin
    exp_align = 1'b0;
    #1;
    check("rst_count",   64'(count),     64'd0);
    check("rst_mem_req", 64'(mem_req),   64'd0);
    check("rst_fwd_hit", 64'(fwd_hit),   64'd0);
    check("rst_align",   64'(align_err), 64'd0);
    check("rst_stall",   64'(cpu_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single store drains next cycle
    step(1'b1, 84, 7, 84, 1'b1);
    check("lat_req", 64'(mem_req), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // fill to full, blocked store, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, ADDR_W'(i * 4), DATA_W'(i + 10), 0, 1'b0);
    step(1'b1, 16, 99, 16, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // youngest same-address store forwards
    step(1'b1, 80, 1, 80, 1'b0);
    step(1'b1, 80, 2, 80, 1'b0);
    step(1'b0, 0, 0, 80, 1'b0);
    step(1'b0, 0, 0, 84, 1'b0);

    // misaligned store
    step(1'b1, 32'h52, 5, 80, 1'b0);
    step(1'b0, 0, 0, 80, 1'b0);
    idle(1'b0);

    // reset mid-drain with three entries
    step(1'b1, 8, 3, 8, 1'b0);
    rst = 1'b1;
    #1;
    mdl_addr.delete(); mdl_data.delete(); exp_q.delete(); exp_align = 1'b0;
    cpu_we = 1'b0;
    check("midrst_req",   64'(mem_req), 64'd0);
    check("midrst_count", 64'(count),   64'd0);
    check("midrst_fwd",   64'(fwd_hit), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 84, 7, 0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // push+pop at count 2 across pointer wrap
    step(1'b1, 100, 1, 0, 1'b0);
    step(1'b1, 104, 2, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, ADDR_W'(200 + i * 4), DATA_W'(i), 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) a = a | ADDR_W'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), a, DATA_W'($urandom),
           ADDR_W'($urandom_range(0, 7) * 4), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
